// File: rtl/sp3a_arb64.sv
// Three-master arbiter onto one downstream bus port (64-bit data, 32-bit address).
// Round-robin or fixed-priority winner selection; writes complete in ISSUE, reads wait for s_ack.
module sp3a_arb64 #(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic        ix_clk,
   input  logic        ix_rst_n,

   input  logic [31:0] m0_addr,
   input  logic [63:0] m0_wdata,
   input  logic [7:0]  m0_be,
   input  logic        m0_rd,
   input  logic        m0_req,
   output logic        m0_ack,
   output logic        m0_gnt,

   input  logic [31:0] m1_addr,
   input  logic [63:0] m1_wdata,
   input  logic [7:0]  m1_be,
   input  logic        m1_rd,
   input  logic        m1_req,
   output logic        m1_ack,
   output logic        m1_gnt,

   input  logic [31:0] m2_addr,
   input  logic [63:0] m2_wdata,
   input  logic [7:0]  m2_be,
   input  logic        m2_rd,
   input  logic        m2_req,
   output logic        m2_ack,
   output logic        m2_gnt,

   output logic [63:0] m_rdata,
   output logic        m_err,

   output logic [31:0] s_addr,
   output logic [63:0] s_wdata,
   output logic [7:0]  s_be,
   output logic        s_rd,
   output logic        s_req,
   input  logic [63:0] s_rdata,
   input  logic        s_busy,
   input  logic        s_ack,
   input  logic        s_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic [1:0]  last_q, last_d;
   logic [31:0] s_addr_q, s_addr_d;
   logic [63:0] s_wdata_q, s_wdata_d;
   logic [7:0]  s_be_q, s_be_d;
   logic        s_rd_q, s_rd_d;
   logic        s_req_q, s_req_d;

   logic [2:0]       req_v;
   logic [2:0][31:0] addr_v;
   logic [2:0][63:0] wdata_v;
   logic [2:0][7:0]  be_v;
   logic [2:0]       rd_v;
   logic [2:0]       ack_v;

   logic [1:0] start_idx;
   logic [1:0] win_idx;
   logic       win_found;

   assign req_v   = {m2_req,   m1_req,   m0_req};
   assign addr_v  = {m2_addr,  m1_addr,  m0_addr};
   assign wdata_v = {m2_wdata, m1_wdata, m0_wdata};
   assign be_v    = {m2_be,    m1_be,    m0_be};
   assign rd_v    = {m2_rd,    m1_rd,    m0_rd};

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   // Fixed priority is round-robin with the search pinned to start at m0.
   always_comb begin
      start_idx = FIXED_PRI ? 2'd0 : wrap3({1'b0, last_q} + 3'd1);
      win_found = 1'b0;
      win_idx   = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (!win_found && req_v[wrap3({1'b0, start_idx} + 3'(k))]) begin
            win_found = 1'b1;
            win_idx   = wrap3({1'b0, start_idx} + 3'(k));
         end
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_be_d    = s_be_q;
      s_rd_d    = s_rd_q;
      s_req_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found && !s_busy) begin
               state_d   = ST_ISSUE;
               gnt_d     = 3'b001 << win_idx;
               last_d    = win_idx;
               s_addr_d  = addr_v[win_idx];
               s_wdata_d = wdata_v[win_idx];
               s_be_d    = be_v[win_idx];
               s_rd_d    = rd_v[win_idx];
               s_req_d   = 1'b1;
            end
         end
         ST_ISSUE: state_d = s_rd_q ? ST_WAIT : ST_IDLE;
         ST_WAIT:  if (s_ack) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Back in IDLE the fields park at zero; write data deliberately keeps its last value.
      if (state_d == ST_IDLE) begin
         gnt_d    = '0;
         s_addr_d = '0;
         s_be_d   = '0;
         s_rd_d   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge ix_clk or negedge ix_rst_n) begin
      if (!ix_rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         last_q    <= 2'd2;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_be_q    <= '0;
         s_rd_q    <= 1'b0;
         s_req_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_be_q    <= s_be_d;
         s_rd_q    <= s_rd_d;
         s_req_q   <= s_req_d;
      end
   end

   assign ack_v = {3{s_ack & (state_q != ST_IDLE)}} & gnt_q;

   assign {m2_ack, m1_ack, m0_ack} = ack_v;
   assign {m2_gnt, m1_gnt, m0_gnt} = gnt_q;

   assign m_rdata = s_rdata;
   assign m_err   = s_err;

   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_be    = s_be_q;
   assign s_rd    = s_rd_q;
   assign s_req   = s_req_q;

endmodule

// File: tb/tb_sp3a_arb64.sv
// Directed bench for sp3a_arb64: a round-robin and a fixed-priority instance share master stimulus.
// The downstream model acks writes combinationally in the s_req cycle; read acks are driven by hand.
module tb_sp3a_arb64;

   logic        ix_clk;
   logic        ix_rst_n;

   logic [31:0] m0_addr, m1_addr, m2_addr;
   logic [63:0] m0_wdata, m1_wdata, m2_wdata;
   logic [7:0]  m0_be, m1_be, m2_be;
   logic        m0_rd, m1_rd, m2_rd;
   logic        m0_req, m1_req, m2_req;

   logic [63:0] s_rdata;
   logic        s_busy, s_err, s_ack_man;

   logic        m0_ack, m1_ack, m2_ack, m0_gnt, m1_gnt, m2_gnt;
   logic [63:0] m_rdata;
   logic        m_err;
   logic [31:0] s_addr;
   logic [63:0] s_wdata;
   logic [7:0]  s_be;
   logic        s_rd, s_req, s_ack;

   logic        fp_m0_ack, fp_m1_ack, fp_m2_ack, fp_m0_gnt, fp_m1_gnt, fp_m2_gnt;
   logic [63:0] fp_m_rdata;
   logic        fp_m_err;
   logic [31:0] fp_s_addr;
   logic [63:0] fp_s_wdata;
   logic [7:0]  fp_s_be;
   logic        fp_s_rd, fp_s_req, fp_s_ack;

   logic [2:0]  gnt, ack, fp_gnt, fp_ack;

   int total = 0;
   int bad   = 0;
   int gnt_cnt;
   int viol;

   assign s_ack    = (s_req & ~s_rd) | s_ack_man;
   assign fp_s_ack = (fp_s_req & ~fp_s_rd) | s_ack_man;

   assign gnt    = {m2_gnt, m1_gnt, m0_gnt};
   assign ack    = {m2_ack, m1_ack, m0_ack};
   assign fp_gnt = {fp_m2_gnt, fp_m1_gnt, fp_m0_gnt};
   assign fp_ack = {fp_m2_ack, fp_m1_ack, fp_m0_ack};

   sp3a_arb64 #(.FIXED_PRI(1'b0)) dut (
      .ix_clk(ix_clk), .ix_rst_n(ix_rst_n),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_rd(m0_rd), .m0_req(m0_req),
      .m0_ack(m0_ack), .m0_gnt(m0_gnt),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_rd(m1_rd), .m1_req(m1_req),
      .m1_ack(m1_ack), .m1_gnt(m1_gnt),
      .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_be(m2_be), .m2_rd(m2_rd), .m2_req(m2_req),
      .m2_ack(m2_ack), .m2_gnt(m2_gnt),
      .m_rdata(m_rdata), .m_err(m_err),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_rd(s_rd), .s_req(s_req),
      .s_rdata(s_rdata), .s_busy(s_busy), .s_ack(s_ack), .s_err(s_err)
   );

   sp3a_arb64 #(.FIXED_PRI(1'b1)) dut_fp (
      .ix_clk(ix_clk), .ix_rst_n(ix_rst_n),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_rd(m0_rd), .m0_req(m0_req),
      .m0_ack(fp_m0_ack), .m0_gnt(fp_m0_gnt),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_rd(m1_rd), .m1_req(m1_req),
      .m1_ack(fp_m1_ack), .m1_gnt(fp_m1_gnt),
      .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_be(m2_be), .m2_rd(m2_rd), .m2_req(m2_req),
      .m2_ack(fp_m2_ack), .m2_gnt(fp_m2_gnt),
      .m_rdata(fp_m_rdata), .m_err(fp_m_err),
      .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_be(fp_s_be), .s_rd(fp_s_rd), .s_req(fp_s_req),
      .s_rdata(s_rdata), .s_busy(s_busy), .s_ack(fp_s_ack), .s_err(s_err)
   );

   initial ix_clk = 1'b0;
   always #5 ix_clk = ~ix_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0]  exp_g [6];
      logic [31:0] exp_a [6];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_a = '{32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1, 32'hA2};

      ix_rst_n  = 1'b0;
      m0_addr = '0; m0_wdata = '0; m0_be = '0; m0_rd = 1'b0; m0_req = 1'b0;
      m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_rd = 1'b0; m1_req = 1'b0;
      m2_addr = '0; m2_wdata = '0; m2_be = '0; m2_rd = 1'b0; m2_req = 1'b0;
      s_rdata = '0; s_busy = 1'b0; s_err = 1'b0; s_ack_man = 1'b0;

      // Reset state
      repeat (2) @(negedge ix_clk);
      #1;
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_fp_gnt", 64'(fp_gnt), 64'd0);
      check("rst_s_req", 64'(s_req), 64'd0);
      check("rst_s_addr", 64'(s_addr), 64'd0);
      check("rst_s_be", 64'(s_be), 64'd0);
      check("rst_s_wdata", s_wdata, 64'd0);
      ix_rst_n = 1'b1;

      // m0 single write
      @(negedge ix_clk);
      m0_addr = 32'h0000_1000; m0_wdata = 64'h1122_3344_5566_7788; m0_be = 8'hFF;
      m0_rd = 1'b0; m0_req = 1'b1;
      #1;
      check("w0_idle_s_req", 64'(s_req), 64'd0);
      @(negedge ix_clk); #1;
      check("w0_gnt", 64'(gnt), 64'b001);
      check("w0_s_req", 64'(s_req), 64'd1);
      check("w0_s_addr", 64'(s_addr), 64'h1000);
      check("w0_s_wdata", s_wdata, 64'h1122_3344_5566_7788);
      check("w0_s_be", 64'(s_be), 64'hFF);
      check("w0_s_rd", 64'(s_rd), 64'd0);
      check("w0_ack", 64'(ack), 64'b001);
      m0_req = 1'b0;
      @(negedge ix_clk); #1;
      check("w0_done_gnt", 64'(gnt), 64'd0);
      check("w0_done_s_req", 64'(s_req), 64'd0);
      check("w0_done_s_addr", 64'(s_addr), 64'd0);
      check("w0_done_s_be", 64'(s_be), 64'd0);
      check("w0_done_wdata_hold", s_wdata, 64'h1122_3344_5566_7788);
      check("w0_done_ack", 64'(ack), 64'd0);

      // m1 read, ack five cycles after s_req; req dropped mid-transfer
      m1_addr = 32'h20; m1_wdata = 64'h55; m1_be = 8'h0F; m1_rd = 1'b1; m1_req = 1'b1;
      @(negedge ix_clk); #1;
      check("r1_gnt", 64'(gnt), 64'b010);
      check("r1_s_req", 64'(s_req), 64'd1);
      check("r1_s_rd", 64'(s_rd), 64'd1);
      check("r1_s_addr", 64'(s_addr), 64'h20);
      check("r1_issue_ack", 64'(ack), 64'd0);
      gnt_cnt = (m1_gnt === 1'b1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge ix_clk);
         if (i == 2) s_err = 1'b1;
         #1;
         if (m1_gnt === 1'b1) gnt_cnt++;
         check("r1_wait_s_req", 64'(s_req), 64'd0);
         check("r1_wait_ack", 64'(ack), 64'd0);
         check("r1_wait_s_addr", 64'(s_addr), 64'h20);
         if (i == 0) m1_req = 1'b0;
         if (i == 2) begin
            check("r1_wait_m_err", 64'(m_err), 64'd1);
            s_err = 1'b0;
         end
      end
      @(negedge ix_clk);
      s_rdata = 64'hDEAD_BEEF_0000_0001; s_ack_man = 1'b1;
      #1;
      if (m1_gnt === 1'b1) gnt_cnt++;
      check("r1_ack", 64'(ack), 64'b010);
      check("r1_rdata", m_rdata, 64'hDEAD_BEEF_0000_0001);
      check("r1_gnt_cycles", 64'(gnt_cnt), 64'd6);
      @(negedge ix_clk);
      s_ack_man = 1'b0;
      #1;
      check("r1_done_gnt", 64'(gnt), 64'd0);
      check("r1_done_s_req", 64'(s_req), 64'd0);
      check("r1_done_s_addr", 64'(s_addr), 64'd0);
      check("r1_done_s_rd", 64'(s_rd), 64'd0);

      // s_ack in IDLE is ignored; m_err passes straight through
      @(negedge ix_clk);
      s_ack_man = 1'b1; s_err = 1'b1;
      #1;
      check("idle_ack_ignored", 64'(ack), 64'd0);
      check("idle_m_err", 64'(m_err), 64'd1);
      @(negedge ix_clk);
      s_ack_man = 1'b0; s_err = 1'b0;
      #1;
      check("idle_ack_gnt", 64'(gnt), 64'd0);
      check("idle_ack_s_req", 64'(s_req), 64'd0);
      check("idle_m_err_clr", 64'(m_err), 64'd0);

      // s_busy blocks grant for 10 cycles, then m2 wins immediately
      s_busy = 1'b1;
      m2_addr = 32'h3000; m2_wdata = 64'hCAFE; m2_be = 8'h3C; m2_rd = 1'b0; m2_req = 1'b1;
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge ix_clk); #1;
         if (gnt !== 3'b000 || s_req !== 1'b0) viol++;
      end
      check("busy_no_grant", 64'(viol), 64'd0);
      s_busy = 1'b0;
      @(negedge ix_clk); #1;
      check("busy_rel_gnt", 64'(gnt), 64'b100);
      check("busy_rel_s_req", 64'(s_req), 64'd1);
      check("busy_rel_s_addr", 64'(s_addr), 64'h3000);
      check("busy_rel_s_be", 64'(s_be), 64'h3C);
      check("busy_rel_ack", 64'(ack), 64'b100);
      m2_req = 1'b0;
      @(negedge ix_clk); #1;
      check("busy_done_gnt", 64'(gnt), 64'd0);

      // Round-robin with all three writing continuously from reset
      ix_rst_n = 1'b0;
      @(negedge ix_clk);
      ix_rst_n = 1'b1;
      m0_addr = 32'hA0; m1_addr = 32'hA1; m2_addr = 32'hA2;
      m0_rd = 1'b0; m1_rd = 1'b0; m2_rd = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1; m2_req = 1'b1;
      #1;
      check("rr_first_idle", 64'(s_req), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge ix_clk); #1;
         check("rr_gnt", 64'(gnt), 64'(exp_g[i]));
         check("rr_s_req", 64'(s_req), 64'd1);
         check("rr_s_addr", 64'(s_addr), 64'(exp_a[i]));
         check("fp_all_gnt", 64'(fp_gnt), 64'b001);
         if (i == 5) begin
            m0_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
         end
         @(negedge ix_clk); #1;
         check("rr_idle_s_req", 64'(s_req), 64'd0);
      end

      // m0 and m2 contend: fixed priority starves m2, round-robin alternates
      m0_req = 1'b1; m2_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ix_clk); #1;
         check("fp_m0_wins", 64'(fp_gnt), 64'b001);
         check("rr_alt", 64'(gnt), (i == 1) ? 64'b100 : 64'b001);
         if (i == 2) m0_req = 1'b0;
         @(negedge ix_clk); #1;
         check("fp_idle_gnt", 64'(fp_gnt), 64'd0);
      end
      @(negedge ix_clk); #1;
      check("fp_m2_after_m0", 64'(fp_gnt), 64'b100);
      check("fp_m2_ack", 64'(fp_ack), 64'b100);
      check("rr_m2_after_m0", 64'(gnt), 64'b100);
      m2_req = 1'b0;
      @(negedge ix_clk); #1;
      check("fp_done_gnt", 64'(fp_gnt), 64'd0);

      // Reset during WAIT of an m1 read abandons the transfer
      m1_addr = 32'h44; m1_rd = 1'b1; m1_req = 1'b1;
      @(negedge ix_clk); #1;
      check("rw_issue_gnt", 64'(gnt), 64'b010);
      @(negedge ix_clk); #1;
      check("rw_wait_gnt", 64'(gnt), 64'b010);
      ix_rst_n = 1'b0;
      #1;
      check("rw_rst_gnt", 64'(gnt), 64'd0);
      check("rw_rst_s_req", 64'(s_req), 64'd0);
      check("rw_rst_s_addr", 64'(s_addr), 64'd0);
      s_ack_man = 1'b1;
      #1;
      check("rw_rst_no_ack", 64'(ack), 64'd0);
      s_ack_man = 1'b0;
      m1_req = 1'b0;
      @(negedge ix_clk);
      ix_rst_n = 1'b1;
      s_ack_man = 1'b1;
      #1;
      check("rw_late_ack", 64'(ack), 64'd0);
      check("rw_late_fp_ack", 64'(fp_ack), 64'd0);
      @(negedge ix_clk);
      s_ack_man = 1'b0;
      #1;
      check("rw_final_gnt", 64'(gnt), 64'd0);
      check("rw_final_s_req", 64'(s_req), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
